// File: rtl/sram_march_tester.sv
// sram_march_tester: built-in march tester for the SRAM controller request port.
// Runs two passes over 0..END_ADDR. Each pass writes every address and then reads
// every address back and compares it. The first pass uses the address pattern and
// the second uses the inverted pattern. At most one read is outstanding at a time.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_start                  1-cycle start pulse (ignored while o_busy)
//   o_req_valid/i_req_ready  request handshake; o_req_we/o_req_addr/o_req_wdata payload
//   i_rd_valid/i_rd_data     read data return strobe
//   o_busy/o_pass/o_fail     status; o_fail_addr/o_fail_data capture the first failure
//   o_led_ok/o_led_err       heartbeat / error indicators
module sram_march_tester #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned END_ADDR   = (2**ADDR_W) - 1,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned BLINK_BITS = 22
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic              o_req_we,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [7:0]        o_req_wdata,
    input  logic              i_rd_valid,
    input  logic [7:0]        i_rd_data,
    output logic              o_busy,
    output logic              o_pass,
    output logic              o_fail,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [7:0]        o_fail_data,
    output logic              o_led_ok,
    output logic              o_led_err
);

    localparam int unsigned       TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned       PAT_W = 20;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(END_ADDR);
    localparam logic [TMR_W-1:0]  TMO   = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_NEXT, S_PASS, S_FAIL
    } state_t;

    // Test pattern. Address bits above ADDR_W-1 count as zero.
    function automatic logic [7:0] f_exp(input logic [ADDR_W-1:0] a, input logic p);
        logic [PAT_W-1:0] w;
        w = PAT_W'(a);
        return w[7:0] ^ w[15:8] ^ {4'h0, w[19:16]} ^ {8{p}};
    endfunction

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [TMR_W-1:0]      r_timer, w_timer_nxt, w_timer_inc;
    logic                  r_pass, w_pass_nxt;
    logic                  r_fail, w_fail_nxt;
    logic [ADDR_W-1:0]     r_fail_addr, w_fail_addr_nxt;
    logic [7:0]            r_fail_data, w_fail_data_nxt;
    logic [BLINK_BITS-1:0] r_blink, w_blink_nxt;
    logic                  r_req_valid, r_req_we, r_busy, r_led_ok;
    logic [7:0]            r_req_wdata;
    logic                  w_accept, w_last, w_busy_nxt, w_show_nxt;

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_phase_nxt     = r_phase;
        w_timer_nxt     = r_timer;
        w_pass_nxt      = r_pass;
        w_fail_nxt      = r_fail;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
        w_accept        = r_req_valid && i_req_ready;
        w_last          = (r_addr == LAST);
        w_timer_inc     = (r_timer == TMO) ? r_timer : r_timer + TMR_W'(1);

        case (r_state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (i_start) begin
                    w_state_nxt     = S_WR;
                    w_addr_nxt      = '0;
                    w_phase_nxt     = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_fail_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_data_nxt = '0;
                end
            end
            S_WR: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = S_RD_REQ;
                        w_addr_nxt  = '0;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end
                end
            end
            S_RD_REQ: begin
                if (w_accept) begin
                    w_state_nxt = S_RD_WAIT;
                    w_timer_nxt = '0;
                end
            end
            S_RD_WAIT: begin
                if (i_rd_valid) begin
                    if (i_rd_data == f_exp(r_addr, r_phase)) begin
                        if (w_last) begin
                            w_state_nxt = S_NEXT;
                        end else begin
                            w_state_nxt = S_RD_REQ;
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                        end
                    end else begin
                        w_state_nxt     = S_FAIL;
                        w_fail_nxt      = 1'b1;
                        w_fail_addr_nxt = r_addr;
                        w_fail_data_nxt = i_rd_data;
                    end
                end else begin
                    // The timer counts the wait cycles that follow the accept cycle
                    w_timer_nxt = w_timer_inc;
                    if (w_timer_inc == TMO) begin
                        w_state_nxt     = S_FAIL;
                        w_fail_nxt      = 1'b1;
                        w_fail_addr_nxt = r_addr;
                        w_fail_data_nxt = 8'h00;
                    end
                end
            end
            S_NEXT: begin
                if (!r_phase) begin
                    w_state_nxt = S_WR;
                    w_phase_nxt = 1'b1;
                    w_addr_nxt  = '0;
                end else begin
                    w_state_nxt = S_PASS;
                    w_pass_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt  = (w_state_nxt == S_WR) || (w_state_nxt == S_RD_REQ) ||
                      (w_state_nxt == S_RD_WAIT) || (w_state_nxt == S_NEXT);
        w_show_nxt  = w_busy_nxt || (w_state_nxt == S_PASS);
        w_blink_nxt = w_show_nxt ? r_blink + BLINK_BITS'(1) : '0;
    end

    // State and registered outputs. The outputs are decoded from the next state so
    // that they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_timer     <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_blink     <= '0;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_busy      <= 1'b0;
            r_led_ok    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_phase     <= w_phase_nxt;
            r_timer     <= w_timer_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_blink     <= w_blink_nxt;
            r_req_valid <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD_REQ);
            r_req_we    <= (w_state_nxt == S_WR);
            r_req_wdata <= (w_state_nxt == S_WR) ? f_exp(w_addr_nxt, w_phase_nxt) : 8'h00;
            r_busy      <= w_busy_nxt;
            r_led_ok    <= w_show_nxt && w_blink_nxt[BLINK_BITS-1];
        end
    end

    assign o_req_valid = r_req_valid;
    assign o_req_we    = r_req_we;
    assign o_req_addr  = r_addr;
    assign o_req_wdata = r_req_wdata;
    assign o_busy      = r_busy;
    assign o_pass      = r_pass;
    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;
    assign o_led_ok    = r_led_ok;
    assign o_led_err   = r_fail;

endmodule
